// File: rtl/rot_loader.sv
// rtl/rot_loader.sv - streams 32-bit words into a rotating nibble register, phase-aligned
module rot_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        flush,
    output logic        set_data,
    output logic [3:0]  nib_out,
    output logic [2:0]  phase,
    output logic        busy,
    output logic        load_done
);

    localparam logic [2:0] PH_BOUNDARY = 3'd6;

    logic [2:0]  r_phase;
    logic [31:0] r_active_word;
    logic        r_active_valid;
    logic [31:0] r_pending_word;
    logic        r_pending_valid;
    logic        r_load_done;

    logic        w_boundary;
    logic        w_accept;
    logic [2:0]  w_sel;

    assign w_boundary = (r_phase == PH_BOUNDARY);
    assign wr_ready   = !r_pending_valid || w_boundary;
    assign w_accept   = wr_valid && wr_ready;
    // The nibble written now is shown one cycle later, when phase has advanced by one.
    assign w_sel      = r_phase + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase         <= 3'd0;
            r_active_word   <= 32'd0;
            r_active_valid  <= 1'b0;
            r_pending_word  <= 32'd0;
            r_pending_valid <= 1'b0;
            r_load_done     <= 1'b0;
        end else begin
            r_phase     <= r_phase + 3'd1;
            r_load_done <= 1'b0;
            if (w_boundary) begin
                r_load_done <= r_active_valid && !flush;
                if (flush) begin
                    r_active_valid  <= 1'b0;
                    r_pending_valid <= 1'b0;
                end else begin
                    if (r_pending_valid) begin
                        r_active_word  <= r_pending_word;
                        r_active_valid <= 1'b1;
                    end else if (w_accept) begin
                        r_active_word  <= wr_data;
                        r_active_valid <= 1'b1;
                    end else begin
                        r_active_valid <= 1'b0;
                    end
                    r_pending_valid <= w_accept && r_pending_valid;
                    if (w_accept) begin
                        r_pending_word <= wr_data;
                    end
                end
            end else if (flush) begin
                r_active_valid  <= 1'b0;
                r_pending_valid <= 1'b0;
            end else if (w_accept) begin
                r_pending_word  <= wr_data;
                r_pending_valid <= 1'b1;
            end
        end
    end

    assign set_data  = r_active_valid;
    assign nib_out   = r_active_valid ? r_active_word[{w_sel, 2'b00} +: 4] : 4'd0;
    assign phase     = r_phase;
    assign busy      = r_active_valid || r_pending_valid;
    assign load_done = r_load_done;

endmodule

// File: tb/tb_rot_loader.sv
// tb/tb_rot_loader.sv - directed self-checking bench for rot_loader
module tb_rot_loader;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        flush;
    logic        set_data;
    logic [3:0]  nib_out;
    logic [2:0]  phase;
    logic        busy;
    logic        load_done;

    int n_tests;
    int n_fail;
    logic [3:0] rot_mem [8];

    rot_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .flush     (flush),
        .set_data  (set_data),
        .nib_out   (nib_out),
        .phase     (phase),
        .busy      (busy),
        .load_done (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p);
        int n;
        n = 0;
        while (phase !== p && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase", {29'd0, phase}, {29'd0, p});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_phase"},    {29'd0, phase},     32'd0);
        check({tag, "_set"},      {31'd0, set_data},  32'd0);
        check({tag, "_nib"},      {28'd0, nib_out},   32'd0);
        check({tag, "_busy"},     {31'd0, busy},      32'd0);
        check({tag, "_done"},     {31'd0, load_done}, 32'd0);
        check({tag, "_ready"},    {31'd0, wr_ready},  32'd1);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_data  = 32'd0;
        wr_valid = 1'b0;
        flush    = 1'b0;
        for (int k = 0; k < 8; k++) rot_mem[k] = 4'hf;

        // reset state and idle phase sequence
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("idle_phase", {29'd0, phase}, i & 7);
            check("idle_set",   {31'd0, set_data},  32'd0);
            check("idle_done",  {31'd0, load_done}, 32'd0);
            check("idle_ready", {31'd0, wr_ready},  32'd1);
        end

        // single load offered at phase 2
        wait_phase(3'd2);
        wr_data  = 32'h7654_3210;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("single_ready_drop", {31'd0, wr_ready}, 32'd0);
        check("single_busy",       {31'd0, busy},     32'd1);
        check("single_set_early",  {31'd0, set_data}, 32'd0);
        wait_phase(3'd7);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("single_set", {31'd0, set_data}, 32'd1);
            check("single_nib", {28'd0, nib_out},  i);
            if (set_data) rot_mem[(phase + 3'd1) & 3'd7] = nib_out;
        end
        @(negedge clk);
        check("single_done",     {31'd0, load_done}, 32'd1);
        check("single_set_off",  {31'd0, set_data},  32'd0);
        check("single_busy_off", {31'd0, busy},      32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) check("single_done_once", {31'd0, load_done}, 32'd0);
            check("rot_data_out", {28'd0, rot_mem[phase]}, {29'd0, phase});
        end

        // back-to-back words
        wait_phase(3'd3);
        wr_data  = 32'hAAAA_AAAA;
        wr_valid = 1'b1;
        @(negedge clk);
        check("b2b_busy4",  {31'd0, busy},     32'd1);
        check("b2b_ready4", {31'd0, wr_ready}, 32'd0);
        wr_data = 32'h5555_5555;
        @(negedge clk);
        check("b2b_ready5", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        check("b2b_ready6", {31'd0, wr_ready}, 32'd1);
        check("b2b_set6",   {31'd0, set_data}, 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("b2b_a_set",  {31'd0, set_data},  32'd1);
            check("b2b_a_nib",  {28'd0, nib_out},   32'hA);
            check("b2b_a_busy", {31'd0, busy},      32'd1);
            check("b2b_a_done", {31'd0, load_done}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_b_set",  {31'd0, set_data},  32'd1);
            check("b2b_b_nib",  {28'd0, nib_out},   32'h5);
            check("b2b_b_busy", {31'd0, busy},      32'd1);
            check("b2b_b_done", {31'd0, load_done}, (i == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("b2b_end_set",  {31'd0, set_data},  32'd0);
        check("b2b_end_busy", {31'd0, busy},      32'd0);
        check("b2b_end_done", {31'd0, load_done}, 32'd1);

        // boundary accept at phase 6 with pending empty
        wait_phase(3'd6);
        wr_data  = 32'h1234_5678;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        check("bnd_phase", {29'd0, phase},    32'd7);
        check("bnd_set",   {31'd0, set_data}, 32'd1);
        check("bnd_nib0",  {28'd0, nib_out},  32'h8);
        @(negedge clk);
        check("bnd_nib1",  {28'd0, nib_out},  32'h7);
        wait_phase(3'd7);
        check("bnd_done",  {31'd0, load_done}, 32'd1);

        // flush at window cycle 3
        wait_phase(3'd1);
        wr_data  = 32'h9ABC_DEF1;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_phase(3'd7);
        check("fl_set_pre", {31'd0, set_data}, 32'd1);
        check("fl_nib_pre", {28'd0, nib_out},  32'h1);
        wait_phase(3'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_phase", {29'd0, phase},    32'd3);
        check("fl_set",   {31'd0, set_data}, 32'd0);
        check("fl_nib",   {28'd0, nib_out},  32'd0);
        check("fl_busy",  {31'd0, busy},     32'd0);
        wait_phase(3'd7);
        check("fl_no_done", {31'd0, load_done}, 32'd0);

        // flush concurrent with a valid word
        wait_phase(3'd4);
        wr_data  = 32'hDEAD_BEEF;
        wr_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        flush    = 1'b0;
        check("flv_busy",  {31'd0, busy},     32'd0);
        check("flv_ready", {31'd0, wr_ready}, 32'd1);
        wait_phase(3'd7);
        check("flv_set",   {31'd0, set_data}, 32'd0);

        // asynchronous reset in the middle of a window
        wait_phase(3'd2);
        wr_data  = 32'hCAFE_F00D;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        wait_phase(3'd1);
        check("ar_set_pre", {31'd0, set_data}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_phase_run", {29'd0, phase},    32'd1);
        check("ar_set_post",  {31'd0, set_data}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
